// File: rtl/samplerz_rd_resp.sv
// SamplerZ operand store read responder: fixed-latency reads, c0 > c1 > write.
// Optional SAMPLERZ_RD_ZERO_EN: zero read data whenever the matching valid is low.
module samplerz_rd_resp #(
   parameter int MEM_ADDR_BITS = 6,
   parameter int READ_DELAY    = 2,
   parameter int DEPTH         = 2 ** MEM_ADDR_BITS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     c0_r_en,
   input  logic [MEM_ADDR_BITS-1:0] c0_r_addr,
   output logic [255:0]             c0_r_data,
   output logic                     c0_r_valid,
   input  logic                     c1_r_en,
   input  logic [MEM_ADDR_BITS-1:0] c1_r_addr,
   output logic                     c1_r_gnt,
   output logic [255:0]             c1_r_data,
   output logic                     c1_r_valid,
   input  logic                     w_en,
   input  logic [MEM_ADDR_BITS-1:0] w_addr,
   input  logic [255:0]             w_data,
   input  logic [3:0]               w_mask,
   output logic                     w_gnt
);

   localparam int LAST = READ_DELAY - 1;

   logic [255:0]             mem [DEPTH];
   logic [255:0]             pd  [READ_DELAY];
   logic [READ_DELAY-1:0]    pv;
   logic [READ_DELAY-1:0]    ptag;
   logic                     c0_acc;
   logic                     rd_acc;
   logic                     rd_tag;
   logic                     rd_ok;
   logic                     wr_ok;
   logic [MEM_ADDR_BITS-1:0] rd_addr;

   // c0 is never stalled; c1 and the host write only use idle array slots
   assign c0_acc   = c0_r_en & ~rst;
   assign c1_r_gnt = c1_r_en & ~c0_r_en & ~rst;
   assign w_gnt    = w_en & ~c0_r_en & ~c1_r_en & ~rst;
   assign rd_acc   = c0_acc | c1_r_gnt;
   assign rd_tag   = ~c0_r_en;
   assign rd_addr  = c0_r_en ? c0_r_addr : c1_r_addr;

   generate
      if (DEPTH < 2 ** MEM_ADDR_BITS) begin : g_rng
         assign rd_ok = int'(rd_addr) < DEPTH;
         assign wr_ok = int'(w_addr) < DEPTH;
      end else begin : g_full
         assign rd_ok = 1'b1;
         assign wr_ok = 1'b1;
      end
   endgenerate

   // lane-masked write of the granted host request
   always_ff @(posedge clk) begin
      if (w_gnt && wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (w_mask[i]) mem[w_addr][64*i +: 64] <= w_data[64*i +: 64];
         end
      end
   end

   // read data pipeline: stage 0 is the registered array read
   always_ff @(posedge clk) begin
      pd[0] <= (rd_acc && rd_ok) ? mem[rd_addr] : '0;
      for (int i = 1; i < READ_DELAY; i++) pd[i] <= pd[i-1];
   end

   // valid/tag pipeline; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         pv   <= '0;
         ptag <= '0;
      end else begin
         pv[0]   <= rd_acc;
         ptag[0] <= rd_tag;
         for (int i = 1; i < READ_DELAY; i++) begin
            pv[i]   <= pv[i-1];
            ptag[i] <= ptag[i-1];
         end
      end
   end

   assign c0_r_valid = pv[LAST] & ~ptag[LAST];
   assign c1_r_valid = pv[LAST] & ptag[LAST];

`ifdef SAMPLERZ_RD_ZERO_EN
   assign c0_r_data = c0_r_valid ? pd[LAST] : '0;
   assign c1_r_data = c1_r_valid ? pd[LAST] : '0;
`else
   logic [255:0] hold0;
   logic [255:0] hold1;

   // remember the last word delivered to each client between responses
   always_ff @(posedge clk) begin
      if (rst) begin
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         if (c0_r_valid) hold0 <= pd[LAST];
         if (c1_r_valid) hold1 <= pd[LAST];
      end
   end

   assign c0_r_data = c0_r_valid ? pd[LAST] : hold0;
   assign c1_r_data = c1_r_valid ? pd[LAST] : hold1;
`endif

endmodule
